// File: rtl/apb_rx_deser.sv
// apb_rx_deser: clocked UART RX deserialiser, majority-vote sampling.
// Optional parity stage compiled in with APB_RX_PARITY_EN.
module apb_rx_deser #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic             rx_en,
  input  logic             rx_in,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
  input  logic             par_odd,
  input  logic             rx_ready,
  output logic [31:0]      rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             par_err,
  output logic             overrun,
  output logic             busy,
  output logic [9:0]       bit_cnto
);

  localparam int TW = $clog2(OVS) + 1;
  localparam logic [TW-1:0] IDX_A = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] IDX_B = TW'(OVS / 2);
  localparam logic [TW-1:0] IDX_C = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] IDX_E = TW'(OVS);
  localparam logic [9:0]    BC_LAST = 10'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef APB_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP1,
    S_STOP2
  } state_t;

  state_t state_q;

  logic              sync1_q;
  logic              sync2_q;
  logic [DIV_W-1:0]  div_q;
  logic [TW-1:0]     tc_q;
  logic [1:0]        smp_q;
  logic [9:0]        bcnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              ferr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ferr_o_q;
  logic              perr_o_q;
  logic              ovr_q;

  logic          rxs;
  logic          en;
  logic          tick;
  logic [TW-1:0] nidx;
  logic          vote;
  logic          vote_at;
  logic          cell_end;
  logic          done;
  logic          fin_ferr;
  logic          fin_perr;

  assign rxs      = sync2_q;
  assign en       = sel & rx_en;
  assign tick     = (state_q != S_IDLE) && (div_q == '0);
  assign nidx     = tc_q + TW'(1);
  assign vote     = (smp_q[0] & smp_q[1]) |
                    (smp_q[0] & rxs) |
                    (smp_q[1] & rxs);
  assign vote_at  = tick && (nidx == IDX_C);
  assign cell_end = tick && (nidx == IDX_E);

  // a frame completes on the final stop-bit vote
  assign done = en && vote_at &&
                ((state_q == S_STOP1 && !stop2) ||
                 (state_q == S_STOP2));

  assign fin_ferr = (state_q == S_STOP2) ? (ferr_q | ~vote) : ~vote;

`ifdef APB_RX_PARITY_EN
  logic pbit_q;
  assign fin_perr = ((^sh_q) ^ pbit_q) != par_odd;
`else
  logic unused_par;
  assign unused_par = par_odd;
  assign fin_perr   = 1'b0;
`endif

  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // oversample tick divider, parked at reload while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else if (!en || state_q == S_IDLE) begin
      div_q <= baud_div;
    end else if (div_q == '0) begin
      div_q <= baud_div;
    end else begin
      div_q <= div_q - DIV_W'(1);
    end
  end

  // frame sequencer: bit-cell timing, votes and shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      smp_q   <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
`ifdef APB_RX_PARITY_EN
      pbit_q  <= 1'b0;
`endif
    end else if (!en) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      tc_q    <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      if (!rxs) begin
        state_q <= S_START;
      end
    end else if (tick) begin
      tc_q <= cell_end ? '0 : nidx;
      if (nidx == IDX_A) begin
        smp_q[0] <= rxs;
      end
      if (nidx == IDX_B) begin
        smp_q[1] <= rxs;
      end
      unique case (state_q)
        S_START: begin
          if (vote_at && vote) begin
            state_q <= S_IDLE;
          end else if (cell_end) begin
            state_q <= S_DATA;
            bcnt_q  <= 10'd1;
          end
        end
        S_DATA: begin
          if (vote_at) begin
            sh_q <= {vote, sh_q[DATA_W-1:1]};
          end
          if (cell_end) begin
            bcnt_q <= bcnt_q + 10'd1;
            if (bcnt_q == BC_LAST) begin
`ifdef APB_RX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_STOP1;
`endif
            end
          end
        end
`ifdef APB_RX_PARITY_EN
        S_PAR: begin
          if (vote_at) begin
            pbit_q <= vote;
          end
          if (cell_end) begin
            bcnt_q  <= bcnt_q + 10'd1;
            state_q <= S_STOP1;
          end
        end
`endif
        S_STOP1: begin
          if (vote_at) begin
            ferr_q <= ~vote;
            if (!stop2) begin
              state_q <= S_IDLE;
              bcnt_q  <= '0;
            end
          end else if (cell_end) begin
            state_q <= S_STOP2;
            bcnt_q  <= bcnt_q + 10'd1;
          end
        end
        S_STOP2: begin
          if (vote_at) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // output holding register and handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_o_q <= 1'b0;
      perr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done && (!valid_q || rx_ready)) begin
        data_q   <= sh_q;
        ferr_o_q <= fin_ferr;
        perr_o_q <= fin_perr;
        valid_q  <= 1'b1;
      end else if (done) begin
        ovr_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = {{(32 - DATA_W){1'b0}}, data_q};
  assign rx_valid  = valid_q;
  assign frame_err = ferr_o_q;
  assign par_err   = perr_o_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);
  assign bit_cnto  = bcnt_q;

endmodule
